// File: rtl/axis_pkt_rate_meter_pkg.sv
// Shared types for the AXI-Stream packet rate meter.
// These are the window-timer state encoding and the per-window result record.
package axis_pkt_rate_meter_pkg;

    localparam int RM_WIN_W = 16;
    localparam int RM_MTU   = 10;
    localparam int RM_CNT_W = RM_WIN_W + 1;
    localparam int RM_LEN_W = RM_MTU + 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } win_state_e;

    typedef struct packed {
        logic [RM_CNT_W-1:0] beats;
        logic [RM_CNT_W-1:0] pkts;
        logic [RM_CNT_W-1:0] stall;
        logic [RM_CNT_W-1:0] idle;
        logic [RM_LEN_W-1:0] max_len;
    } meas_t;

endpackage

// File: rtl/rate_meter_window_timer.sv
// Back-to-back measurement window timer.
// It flags the load cycle, every active cycle and the last cycle of each window.
module rate_meter_window_timer
    import axis_pkt_rate_meter_pkg::*;
#(
    parameter int WIN_W = RM_WIN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [WIN_W-1:0] window_len,
    output logic             win_active,
    output logic             win_first,
    output logic             win_last
);

    localparam logic [WIN_W-1:0] ONE = {{(WIN_W-1){1'b0}}, 1'b1};

    win_state_e       state_reg, state_next;
    logic [WIN_W-1:0] remaining_reg, remaining_next, remaining_cur;

    // Leaving RUN through IDLE on the last cycle lets the next enabled cycle
    // reload window_len exactly as a fresh start would, so windows abut with no gap.
    always_comb begin
        state_next     = state_reg;
        remaining_next = remaining_reg;
        remaining_cur  = remaining_reg;
        win_active     = 1'b0;
        win_first      = 1'b0;
        win_last       = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (enable) begin
                    win_active    = 1'b1;
                    win_first     = 1'b1;
                    remaining_cur = window_len;
                end
            end
            ST_RUN: begin
                win_active = enable;
            end
            default: begin
                win_active = 1'b0;
            end
        endcase
        if (win_active) begin
            win_last       = (remaining_cur == '0);
            remaining_next = remaining_cur - ONE;
            state_next     = win_last ? ST_IDLE : ST_RUN;
        end else begin
            state_next = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            remaining_reg <= '0;
        end else begin
            state_reg     <= state_next;
            remaining_reg <= remaining_next;
        end
    end

endmodule

// File: rtl/axis_pkt_rate_meter.sv
// Pass-through AXI-Stream monitor measuring beats, packets, stalls, idles and the
// longest packet over fixed back-to-back windows. The datapath is pure wiring.
module axis_pkt_rate_meter
    import axis_pkt_rate_meter_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int WIN_W  = RM_WIN_W,
    parameter int MTU    = RM_MTU
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [WIN_W-1:0]  window_len,
    input  logic [DATA_W-1:0] i_tdata,
    input  logic              i_tlast,
    input  logic              i_tvalid,
    output logic              i_tready,
    output logic [DATA_W-1:0] o_tdata,
    output logic              o_tlast,
    output logic              o_tvalid,
    input  logic              o_tready,
    output logic              meas_valid,
    output logic [WIN_W:0]    meas_beats,
    output logic [WIN_W:0]    meas_pkts,
    output logic [WIN_W:0]    meas_stall,
    output logic [WIN_W:0]    meas_idle,
    output logic [MTU:0]      meas_max_len
);

    localparam int CNT_W = WIN_W + 1;
    localparam int LEN_W = MTU + 1;
    localparam int N_EVT = 4;
    localparam logic [LEN_W-1:0] LEN_ONE = {{MTU{1'b0}}, 1'b1};
    localparam logic [LEN_W-1:0] LEN_MAX = {1'b1, {MTU{1'b0}}};

    assign o_tdata  = i_tdata;
    assign o_tlast  = i_tlast;
    assign o_tvalid = i_tvalid;
    assign i_tready = o_tready;

    logic win_active, win_first, win_last;

    rate_meter_window_timer #(
        .WIN_W(WIN_W)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .window_len (window_len),
        .win_active (win_active),
        .win_first  (win_first),
        .win_last   (win_last)
    );

    logic beat, pkt_end;
    logic [N_EVT-1:0] evt;

    assign beat    = i_tvalid & o_tready;
    assign pkt_end = beat & i_tlast;
    assign evt[0]  = beat;
    assign evt[1]  = pkt_end;
    assign evt[2]  = i_tvalid & ~o_tready;
    assign evt[3]  = ~i_tvalid;

    // acc_sum is each accumulator including the current cycle's event; on the
    // load cycle the previous window's total is dropped rather than added to.
    logic [N_EVT-1:0][CNT_W-1:0] acc_sum;

    generate
        for (genvar gi = 0; gi < N_EVT; gi++) begin : g_acc
            logic [CNT_W-1:0] acc_reg;
            logic [CNT_W-1:0] acc_next;

            always_comb begin
                acc_next = (win_first ? '0 : acc_reg) + {{(CNT_W-1){1'b0}}, evt[gi]};
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    acc_reg <= '0;
                end else if (win_active) begin
                    acc_reg <= acc_next;
                end
            end

            assign acc_sum[gi] = acc_next;
        end
    endgenerate

    // Packet length runs independently of the window so straddling packets are whole.
    logic [LEN_W-1:0] len_reg, pkt_len;
    logic             sop_reg;

    always_comb begin
        if (sop_reg) begin
            pkt_len = LEN_ONE;
        end else if (len_reg == LEN_MAX) begin
            pkt_len = LEN_MAX;
        end else begin
            pkt_len = len_reg + LEN_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            len_reg <= '0;
            sop_reg <= 1'b1;
        end else if (beat) begin
            if (i_tlast) begin
                len_reg <= '0;
                sop_reg <= 1'b1;
            end else begin
                len_reg <= pkt_len;
                sop_reg <= 1'b0;
            end
        end
    end

    logic [LEN_W-1:0] max_reg, max_base, max_next;

    always_comb begin
        max_base = win_first ? '0 : max_reg;
        max_next = max_base;
        if (pkt_end && (pkt_len > max_base)) begin
            max_next = pkt_len;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            max_reg <= '0;
        end else if (win_active) begin
            max_reg <= max_next;
        end
    end

    meas_t meas_reg;
    logic  meas_valid_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            meas_reg       <= '0;
            meas_valid_reg <= 1'b0;
        end else begin
            meas_valid_reg <= win_last;
            if (win_last) begin
                meas_reg.beats   <= acc_sum[0];
                meas_reg.pkts    <= acc_sum[1];
                meas_reg.stall   <= acc_sum[2];
                meas_reg.idle    <= acc_sum[3];
                meas_reg.max_len <= max_next;
            end
        end
    end

    assign meas_valid   = meas_valid_reg;
    assign meas_beats   = meas_reg.beats;
    assign meas_pkts    = meas_reg.pkts;
    assign meas_stall   = meas_reg.stall;
    assign meas_idle    = meas_reg.idle;
    assign meas_max_len = meas_reg.max_len;

endmodule
